// File: rtl/ex_stage_mdu_if.sv
// Execute-stage bus: ID/EX operands and controls in, EX/MEM register and
// hazard-unit handshake out.
//   master : ID/EX side and hazard unit (drives E-stage fields, observes results)
//   slave  : ex_stage_mdu (consumes E-stage fields, drives busyE/pcsrcE/M fields)
interface ex_stage_mdu_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
);
  // E-stage inputs
  logic            validE;
  logic            flushE;
  logic            regwriteE;
  logic            memwriteE;
  logic            jumpE;
  logic            branchE;
  logic            alusrcE;
  logic [1:0]      resultsrcE;
  logic [1:0]      forwardAE;
  logic [1:0]      forwardBE;
  logic [3:0]      alucontrolE;
  logic [XLEN-1:0] rd1E;
  logic [XLEN-1:0] rd2E;
  logic [XLEN-1:0] pcE;
  logic [XLEN-1:0] pcplus4E;
  logic [XLEN-1:0] immextE;
  logic [XLEN-1:0] resultW;
  logic [REGW-1:0] rdE;

  // hazard / fetch feedback (combinational)
  logic            busyE;
  logic            pcsrcE;
  logic [XLEN-1:0] pctargetE;

  // EX/MEM register
  logic            validM;
  logic            regwriteM;
  logic            memwriteM;
  logic [1:0]      resultsrcM;
  logic [XLEN-1:0] aluresultM;
  logic [XLEN-1:0] writedataM;
  logic [XLEN-1:0] pcplus4M;
  logic [REGW-1:0] rdM;

  modport master (
    output validE, flushE, regwriteE, memwriteE, jumpE, branchE, alusrcE,
           resultsrcE, forwardAE, forwardBE, alucontrolE,
           rd1E, rd2E, pcE, pcplus4E, immextE, resultW, rdE,
    input  busyE, pcsrcE, pctargetE,
           validM, regwriteM, memwriteM, resultsrcM,
           aluresultM, writedataM, pcplus4M, rdM
  );

  modport slave (
    input  validE, flushE, regwriteE, memwriteE, jumpE, branchE, alusrcE,
           resultsrcE, forwardAE, forwardBE, alucontrolE,
           rd1E, rd2E, pcE, pcplus4E, immextE, resultW, rdE,
    output busyE, pcsrcE, pctargetE,
           validM, regwriteM, memwriteM, resultsrcM,
           aluresultM, writedataM, pcplus4M, rdM
  );
endinterface

// File: rtl/ex_stage_mdu.sv
// Execute stage: operand forwarding, single-cycle ALU, branch/jump resolution,
// iterative unsigned multiply/divide with a stall request, and the EX/MEM
// pipeline register with valid bit, flush and bubble insertion.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - ex_stage_mdu_if.slave (E-stage inputs, busyE/pcsrcE/pctargetE, M outputs)
module ex_stage_mdu #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REGW   = 5,
  parameter bit          MDU_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  ex_stage_mdu_if.slave  bus
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;     // product low half / quotient
  logic [XLEN-1:0] opb_q, opb_d;   // latched multiplicand / divisor
  logic [1:0]      op_q, op_d;     // bit1: divide, bit0: high-half/remainder

  logic [XLEN-1:0] srca, srcb, writedata;
  logic [XLEN-1:0] alu_res, mdu_res, aluresult;
  logic [SHW-1:0]  shamt;
  logic            is_mdu, zero, busy_c;
  logic [XLEN:0]   sum, shifted, diff;

  // Forwarding muxes
  always_comb begin
    case (bus.forwardAE)
      2'b00:   srca = bus.rd1E;
      2'b01:   srca = bus.resultW;
      2'b10:   srca = bus.aluresultM;
      default: srca = '0;
    endcase
    case (bus.forwardBE)
      2'b00:   writedata = bus.rd2E;
      2'b01:   writedata = bus.resultW;
      2'b10:   writedata = bus.aluresultM;
      default: writedata = '0;
    endcase
  end

  assign srcb   = bus.alusrcE ? bus.immextE : writedata;
  assign shamt  = srcb[SHW-1:0];
  assign is_mdu = (bus.alucontrolE[3:2] == 2'b11);

  // Single-cycle ALU; MDU opcodes fall back to add when the MDU is absent
  always_comb begin
    alu_res = '0;
    case (bus.alucontrolE)
      4'b0000: alu_res = srca + srcb;
      4'b0001: alu_res = srca - srcb;
      4'b0010: alu_res = srca & srcb;
      4'b0011: alu_res = srca | srcb;
      4'b0100: alu_res = srca ^ srcb;
      4'b0101: alu_res = XLEN'($signed(srca) < $signed(srcb));
      4'b0110: alu_res = XLEN'(srca < srcb);
      4'b0111: alu_res = srca << shamt;
      4'b1000: alu_res = srca >> shamt;
      4'b1001: alu_res = $signed(srca) >>> shamt;
      4'b1100, 4'b1101, 4'b1110, 4'b1111: alu_res = srca + srcb;
      default: alu_res = '0;
    endcase
  end

  assign mdu_res   = op_q[0] ? acc_q : lo_q;
  assign aluresult = (MDU_EN && is_mdu) ? mdu_res : alu_res;
  assign zero      = (aluresult == '0);

  assign bus.pctargetE = bus.pcE + bus.immextE;
  assign bus.pcsrcE    = bus.validE & ~bus.flushE & ((bus.branchE & zero) | bus.jumpE);

  // Radix-2 step datapath: shift-add multiply and restoring divide
  assign sum     = {1'b0, acc_q} + {1'b0, opb_q};
  assign shifted = {acc_q, lo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, opb_q};

  // MDU next-state and stall request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    op_d    = op_q;
    busy_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MDU_EN && bus.validE && !bus.flushE && is_mdu) begin
          busy_c  = 1'b1;
          acc_d   = '0;
          lo_d    = srca;
          opb_d   = srcb;
          op_d    = bus.alucontrolE[1:0];
          cnt_d   = CW'(XLEN);
          state_d = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (bus.flushE) begin
          state_d = IDLE;
        end else begin
          if (!op_q[1]) begin
            if (lo_q[0]) {acc_d, lo_d} = {sum, lo_q[XLEN-1:1]};
            else         {acc_d, lo_d} = {1'b0, acc_q, lo_q[XLEN-1:1]};
          end else begin
            // borrow out means the trial subtraction failed: restore
            if (diff[XLEN]) begin
              acc_d = shifted[XLEN-1:0];
              lo_d  = {lo_q[XLEN-2:0], 1'b0};
            end else begin
              acc_d = diff[XLEN-1:0];
              lo_d  = {lo_q[XLEN-2:0], 1'b1};
            end
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // No stall is requested while the stage is held in reset
  assign bus.busyE = rst & busy_c;

  // MDU state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
    end
  end

  // EX/MEM register: flush or stall inserts a bubble, data fields hold
  logic            valid_m, regwrite_m, memwrite_m;
  logic [1:0]      resultsrc_m;
  logic [XLEN-1:0] aluresult_m, writedata_m, pcplus4_m;
  logic [REGW-1:0] rd_m;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_m     <= 1'b0;
      regwrite_m  <= 1'b0;
      memwrite_m  <= 1'b0;
      resultsrc_m <= '0;
      aluresult_m <= '0;
      writedata_m <= '0;
      pcplus4_m   <= '0;
      rd_m        <= '0;
    end else if (bus.flushE || busy_c) begin
      valid_m    <= 1'b0;
      regwrite_m <= 1'b0;
      memwrite_m <= 1'b0;
    end else begin
      valid_m     <= bus.validE;
      regwrite_m  <= bus.regwriteE & bus.validE;
      memwrite_m  <= bus.memwriteE & bus.validE;
      resultsrc_m <= bus.resultsrcE;
      aluresult_m <= aluresult;
      writedata_m <= writedata;
      pcplus4_m   <= bus.pcplus4E;
      rd_m        <= bus.rdE;
    end
  end

  assign bus.validM     = valid_m;
  assign bus.regwriteM  = regwrite_m;
  assign bus.memwriteM  = memwrite_m;
  assign bus.resultsrcM = resultsrc_m;
  assign bus.aluresultM = aluresult_m;
  assign bus.writedataM = writedata_m;
  assign bus.pcplus4M   = pcplus4_m;
  assign bus.rdM        = rd_m;

endmodule
